// File: rtl/sram_note_fetch_if.sv
// Signal bundle for sram_note_fetch: the SRAM read port plus the player-side
// valid/ready instruction handshake and status.
interface sram_note_fetch_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int LVL_W  = 3
);
  logic              EN;
  logic [ADDR_W-1:0] SRAM_A;
  logic [DATA_W-1:0] SRAM_D;
  logic              SRAM_CE;
  logic              SRAM_OE;
  logic              SRAM_LB;
  logic              SRAM_UB;
  logic              SRAM_WE;
  logic [DATA_W-1:0] INS;
  logic              INS_VALID;
  logic              INS_READY;
  logic [LVL_W-1:0]  LEVEL;
  logic              DONE;

  modport master (
    input  EN, SRAM_D, INS_READY,
    output SRAM_A, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB, SRAM_WE,
           INS, INS_VALID, LEVEL, DONE
  );

  modport slave (
    output EN, SRAM_D, INS_READY,
    input  SRAM_A, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB, SRAM_WE,
           INS, INS_VALID, LEVEL, DONE
  );
endinterface

// File: rtl/sram_note_fetch.sv
// Read-only SRAM fetch FSM feeding a first-word-fall-through FIFO of note
// instructions. Define SRAM_NOTE_FETCH_LOOP_EN to repeat the song at END_WORD.
//
// state  | meaning
// S_IDLE | no fetch in flight; issue when EN and FIFO has room
// S_WAIT | SRAM_A presented, counting wait states before sampling SRAM_D
// S_HALT | end-of-song marker seen; left only by RST
module sram_note_fetch #(
  parameter int                ADDR_W      = 18,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_CYCLES = 2,
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [DATA_W-1:0] END_WORD    = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              RST,
  sram_note_fetch_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] sram_a, sram_a_nxt;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [LVL_W-1:0]  level;
  logic              ins_valid;

  assign ins_valid = (level != '0);
  assign pop       = ins_valid && bus.INS_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      pc       <= START_ADDR;
      sram_a   <= START_ADDR;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      sram_a   <= sram_a_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    sram_a_nxt   = sram_a;
    wait_cnt_nxt = wait_cnt;
    push         = 1'b0;
    case (state)
      S_IDLE: begin
        // A same-cycle pop frees a slot, so a full FIFO may still issue.
        if (bus.EN && ((level != LVL_FULL) || pop)) begin
          state_nxt    = S_WAIT;
          sram_a_nxt   = pc;
          wait_cnt_nxt = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) begin
          if (bus.SRAM_D != END_WORD) begin
            push      = 1'b1;
            pc_nxt    = pc + 1'b1;
            state_nxt = S_IDLE;
          end else begin
`ifdef SRAM_NOTE_FETCH_LOOP_EN
            // A marker at the song start means an empty song: halt, don't spin.
            if (pc == START_ADDR) begin
              state_nxt = S_HALT;
            end else begin
              pc_nxt    = START_ADDR;
              state_nxt = S_IDLE;
            end
`else
            state_nxt = S_HALT;
`endif
          end
        end else begin
          wait_cnt_nxt = wait_cnt - 1'b1;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= bus.SRAM_D;
  end

  assign bus.SRAM_A    = sram_a;
  assign bus.SRAM_CE   = 1'b0;
  assign bus.SRAM_OE   = 1'b0;
  assign bus.SRAM_LB   = 1'b0;
  assign bus.SRAM_UB   = 1'b0;
  assign bus.SRAM_WE   = 1'b1;
  assign bus.INS       = ins_valid ? fifo_mem[rd_ptr] : '0;
  assign bus.INS_VALID = ins_valid;
  assign bus.LEVEL     = level;
  assign bus.DONE      = (state == S_HALT) && (level == '0);

endmodule

// File: tb/tb_sram_note_fetch.sv
// Bench for sram_note_fetch: directed scenarios plus randomized EN/INS_READY runs
// over random song images, checked against the expected instruction stream.
module tb_sram_note_fetch;

  localparam int          ADDR_W = 18;
  localparam int          DATA_W = 16;
  localparam int          WC     = 2;
  localparam int          DEPTH  = 4;
  localparam int          LVL_W  = 3;
  localparam logic [15:0] END_W  = 16'hFFFF;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #10 CLK = ~CLK;

  sram_note_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LVL_W(LVL_W)) bus ();
  sram_note_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LVL_W(LVL_W)) wbus ();

  sram_note_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WC), .FIFO_DEPTH(DEPTH),
    .START_ADDR(18'd0), .END_WORD(END_W)
  ) u_dut (.CLK(CLK), .RST(RST), .bus(bus));

  sram_note_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WC), .FIFO_DEPTH(DEPTH),
    .START_ADDR(18'h3FFFF), .END_WORD(END_W)
  ) u_wrap (.CLK(CLK), .RST(RST), .bus(wbus));

  // asynchronous SRAM models
  logic [15:0] img [64];
  assign bus.SRAM_D  = img[bus.SRAM_A[5:0]];
  assign wbus.SRAM_D = (wbus.SRAM_A == 18'h3FFFF) ? 16'h0005 :
                       (wbus.SRAM_A == 18'h00000) ? 16'h0006 : 16'hFFFF;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int inv_bad  = 0;
  logic [15:0] pop_q[$];
  int          pop_cyc[$];
  logic [15:0] wpop_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.INS_VALID && bus.INS_READY) begin
        pop_q.push_back(bus.INS);
        pop_cyc.push_back(cyc);
      end
      if (wbus.INS_VALID && wbus.INS_READY) wpop_q.push_back(wbus.INS);
      if ((bus.INS_VALID !== (bus.LEVEL != 0)) || (bus.LEVEL > DEPTH)) inv_bad++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic clear_q();
    pop_q.delete();
    pop_cyc.delete();
    wpop_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    clear_q();
  endtask

  function automatic logic [15:0] rnd_word();
    logic [15:0] w;
    w = 16'($urandom_range(0, 65534));
    if ($urandom_range(0, 7) == 0) w = 16'hFFFE;
    return w;
  endfunction

  task automatic load_image(input int len);
    for (int i = 0; i < 64; i++) img[i] = END_W;
    for (int i = 0; i < len; i++) img[i] = rnd_word();
  endtask

  // Expected stream: image words from START_ADDR up to the marker, repeated when looping.
  task automatic check_stream(input string tag, input int len);
    int n;
    int bad;
    n   = pop_q.size();
    bad = -1;
    for (int i = 0; i < n; i++) begin
      if (bad < 0 && pop_q[i] !== img[i % len]) bad = i;
    end
    if (bad < 0) check_val({tag, "_order"}, 0, 0 + (n < 0));
    else         check_val({tag, "_order"}, pop_q[bad], img[bad % len]);
`ifdef SRAM_NOTE_FETCH_LOOP_EN
    check_val({tag, "_count_gt_len"}, n > len, 1);
    check_val({tag, "_done"}, bus.DONE, 0);
`else
    check_val({tag, "_count"}, n, len);
    check_val({tag, "_done"}, bus.DONE, 1);
    check_val({tag, "_sram_a"}, bus.SRAM_A, len);
    check_val({tag, "_level"}, bus.LEVEL, 0);
`endif
  endtask

  initial begin
    int n;
    int len;
    #(1_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    bus.EN = 1'b0;
    bus.INS_READY = 1'b0;
    wbus.EN = 1'b0;
    wbus.INS_READY = 1'b0;
    for (int i = 0; i < 64; i++) img[i] = END_W;

    // T1: basic song 11,22,33,marker
    img[0] = 16'h0011; img[1] = 16'h0022; img[2] = 16'h0033; img[3] = END_W;
    bus.EN = 1'b1;
    bus.INS_READY = 1'b1;
    RST = 1'b1;
    step();
    step();
    check_val("rst_level", bus.LEVEL, 0);
    check_val("rst_valid", bus.INS_VALID, 0);
    check_val("rst_ins", bus.INS, 0);
    check_val("rst_sram_a", bus.SRAM_A, 0);
    check_val("rst_done", bus.DONE, 0);
    check_val("rst_we", {bus.SRAM_WE, bus.SRAM_CE, bus.SRAM_OE, bus.SRAM_LB, bus.SRAM_UB}, 5'b10000);
    RST = 1'b0;
    clear_q();
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.INS_VALID && n < 20);
    check_val("t1_latency", n, WC + 1);
    steps(60);
    check_val("t1_pops_ge3", pop_q.size() >= 3, 1);
    if (pop_q.size() >= 3) begin
      check_val("t1_gap0", pop_cyc[1] - pop_cyc[0], WC + 1);
      check_val("t1_gap1", pop_cyc[2] - pop_cyc[1], WC + 1);
    end
    check_stream("t1", 3);

    // T2: consumer stalled, FIFO fills and holds; one pop allows one fetch
    load_image(8);
    bus.INS_READY = 1'b0;
    do_reset();
    steps(40);
    check_val("t2_full_level", bus.LEVEL, DEPTH);
    check_val("t2_full_sram_a", bus.SRAM_A, 3);
    check_val("t2_full_head", bus.INS, img[0]);
    check_val("t2_no_pops", pop_q.size(), 0);
    bus.INS_READY = 1'b1;
    step();
    bus.INS_READY = 1'b0;
    check_val("t2_pop_sram_a", bus.SRAM_A, 4);
    check_val("t2_pop_level", bus.LEVEL, DEPTH - 1);
    steps(20);
    check_val("t2_refill_level", bus.LEVEL, DEPTH);
    check_val("t2_refill_sram_a", bus.SRAM_A, 4);
    check_val("t2_refill_head", bus.INS, img[1]);
    bus.INS_READY = 1'b1;
    steps(80);
    check_stream("t2", 8);

    // T3: LEVEL=2 steady state with push and pop on the same edge
    load_image(16);
    bus.INS_READY = 1'b0;
    do_reset();
    steps(6);
    check_val("t3_level_init", bus.LEVEL, 2);
    for (int k = 0; k < 5; k++) begin
      steps(2);
      bus.INS_READY = 1'b1;
      step();
      bus.INS_READY = 1'b0;
      check_val("t3_level", bus.LEVEL, 2);
      check_val("t3_pops", pop_q.size(), k + 1);
      if (pop_q.size() > k) check_val("t3_word", pop_q[k], img[k]);
      check_val("t3_head", bus.INS, img[k + 1]);
    end

    // T4: reset while a fetch is in flight
    load_image(6);
    bus.INS_READY = 1'b0;
    do_reset();
    steps(7);
    check_val("t4_inflight_a", bus.SRAM_A, 2);
    RST = 1'b1;
    step();
    check_val("t4_rst_level", bus.LEVEL, 0);
    check_val("t4_rst_valid", bus.INS_VALID, 0);
    check_val("t4_rst_sram_a", bus.SRAM_A, 0);
    RST = 1'b0;
    clear_q();
    bus.INS_READY = 1'b1;
    steps(60);
    check_stream("t4", 6);

    // T5: random images with random EN / INS_READY
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(5, 30);
      load_image(len);
      bus.EN = 1'b1;
      bus.INS_READY = 1'b0;
      do_reset();
      for (int c = 0; c < 300; c++) begin
        bus.EN        = ($urandom_range(0, 3) != 0);
        bus.INS_READY = $urandom_range(0, 1);
        step();
      end
      bus.EN = 1'b1;
      bus.INS_READY = 1'b1;
`ifdef SRAM_NOTE_FETCH_LOOP_EN
      steps(200);
`else
      n = 0;
      while (!bus.DONE && n < 400) begin
        step();
        n++;
      end
`endif
      check_stream($sformatf("t5_%0d", r), len);
    end

    // T6: address wrap from 2^18-1 to 0
    bus.EN = 1'b0;
    bus.INS_READY = 1'b0;
    wbus.EN = 1'b1;
    wbus.INS_READY = 1'b1;
    do_reset();
    steps(40);
`ifdef SRAM_NOTE_FETCH_LOOP_EN
    check_val("t6_count_ge4", wpop_q.size() >= 4, 1);
    if (wpop_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) check_val("t6_word", wpop_q[i], (i % 2) ? 16'h0006 : 16'h0005);
    end
    check_val("t6_done", wbus.DONE, 0);
`else
    check_val("t6_count", wpop_q.size(), 2);
    if (wpop_q.size() >= 2) begin
      check_val("t6_word0", wpop_q[0], 16'h0005);
      check_val("t6_word1", wpop_q[1], 16'h0006);
    end
    check_val("t6_done", wbus.DONE, 1);
    check_val("t6_sram_a", wbus.SRAM_A, 1);
`endif

    check_val("invariants", inv_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
